clk_time_ctrl: RTL and testbench

Timekeeping controller for the digital clock. It divides `clk` by `DIV` to produce a one-second tick and keeps the hour, minute and second counters. A three-state mode FSM lets the user set the time from single-cycle button pulses. It sits between the prescaler stage and the display/segment decode.

---
 rtl/clk_time_ctrl_if.sv | 20 ++
 rtl/clk_time_ctrl.sv | 111 +++++++++++
 tb/tb_clk_time_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/clk_time_ctrl_if.sv
// rtl/clk_time_ctrl_if.sv - button pulses in, time/mode/tick out for the timekeeping controller
interface clk_time_ctrl_if;
  logic       mode_pls;
  logic       up_pls;
  logic       tick;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [1:0] mode;

  modport master (
    output mode_pls, up_pls,
    input  tick, sec, min, hour, mode
  );

  modport slave (
    input  mode_pls, up_pls,
    output tick, sec, min, hour, mode
  );
endinterface

// File: rtl/clk_time_ctrl.sv
// rtl/clk_time_ctrl.sv - second prescaler, hh:mm:ss counters and RUN/SET_HR/SET_MIN mode FSM
module clk_time_ctrl #(
  parameter int unsigned DIV = 6
) (
  input  logic            clk,
  input  logic            rst,
  clk_time_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_e;

  localparam logic [15:0] CNT_LAST = 16'(DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  sec_q, sec_d;
  logic [5:0]  min_q, min_d;
  logic [4:0]  hour_q, hour_d;
  logic        tick_w;
  logic [1:0]  mode_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.mode_pls) begin
      case (state_q)
        RUN:     state_d = SET_HR;
        SET_HR:  state_d = SET_MIN;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    mode_w = state_q;
    tick_w = (state_q == RUN) && (cnt_q == CNT_LAST);
  end

  assign bus.mode = mode_w;
  assign bus.tick = tick_w;
  assign bus.sec  = sec_q;
  assign bus.min  = min_q;
  assign bus.hour = hour_q;

  always_comb begin
    cnt_d  = '0;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    case (state_q)
      RUN: begin
        // Leaving RUN drops the partial second; the tick's increment still lands.
        if (!bus.mode_pls && !tick_w) begin
          cnt_d = cnt_q + 16'd1;
        end
        if (tick_w) begin
          if (sec_q == 6'd59) begin
            sec_d = '0;
            if (min_q == 6'd59) begin
              min_d  = '0;
              hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
      end
      SET_HR: begin
        if (bus.up_pls && !bus.mode_pls) begin
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end
      end
      SET_MIN: begin
        if (bus.mode_pls) begin
          sec_d = '0;
        end else if (bus.up_pls) begin
          min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
    end
  end

endmodule

// File: tb/tb_clk_time_ctrl.sv
// tb/tb_clk_time_ctrl.sv - scoreboard bench for clk_time_ctrl at DIV=6 and DIV=2
module tb_clk_time_ctrl;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  clk_time_ctrl_if bus_a ();
  clk_time_ctrl_if bus_b ();

  clk_time_ctrl #(.DIV(6)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));
  clk_time_ctrl #(.DIV(2)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.slave));

  // sel: 0 sec, 1 min, 2 hour, 3 mode, 4 tick, 5 tick count, 6 clear tick count; +10 for DIV=2 unit
  typedef struct {
    int    sel;
    int    exp;
    string name;
  } item_t;

  item_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    tick_cnt_a = 0;

  always @(negedge clk) begin
    if (bus_a.tick === 1'b1) tick_cnt_a = tick_cnt_a + 1;
    while (q.size() > 0) begin
      item_t e;
      int    act;
      e = q.pop_front();
      act = -1;
      case (e.sel)
        0:  act = int'(bus_a.sec);
        1:  act = int'(bus_a.min);
        2:  act = int'(bus_a.hour);
        3:  act = int'(bus_a.mode);
        4:  act = int'(bus_a.tick);
        5:  act = tick_cnt_a;
        10: act = int'(bus_b.sec);
        11: act = int'(bus_b.min);
        12: act = int'(bus_b.hour);
        13: act = int'(bus_b.mode);
        14: act = int'(bus_b.tick);
        default: act = -1;
      endcase
      if (e.sel == 6) begin
        tick_cnt_a = 0;
      end else begin
        n_tests = n_tests + 1;
        if (act != e.exp) begin
          n_fail = n_fail + 1;
          $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_a(input int sel, input int v, input string nm);
    q.push_back('{sel, v, nm});
  endtask

  task automatic exp_time_a(input int h, input int m, input int s, input string nm);
    exp_a(2, h, {nm, ".hour"});
    exp_a(1, m, {nm, ".min"});
    exp_a(0, s, {nm, ".sec"});
  endtask

  task automatic pulse_a(input logic m, input logic u, input int n);
    bus_a.mode_pls = m;
    bus_a.up_pls   = u;
    step(n);
    bus_a.mode_pls = 1'b0;
    bus_a.up_pls   = 1'b0;
  endtask

  initial begin
    bus_a.mode_pls = 1'b0;
    bus_a.up_pls   = 1'b0;
    bus_b.mode_pls = 1'b0;
    bus_b.up_pls   = 1'b0;
    step(2);
    q.push_back('{14, 0, "b_reset.tick"});

    // Reset asserted mid-count, values visible before any further edge
    rst_a = 1'b0;
    step(3);
    rst_a = 1'b1;
    exp_time_a(0, 0, 0, "reset");
    exp_a(3, 0, "reset.mode");
    exp_a(4, 0, "reset.tick");
    step(2);
    rst_a = 1'b0;

    step(4);
    exp_a(4, 0, "edge4.tick");
    step(1);
    exp_a(4, 1, "edge5.tick");
    exp_a(0, 0, "edge5.sec");
    step(1);
    exp_a(0, 1, "edge6.sec");
    exp_a(4, 0, "edge6.tick");
    step(54);
    exp_a(0, 10, "edge60.sec");

    pulse_a(1'b0, 1'b1, 1);
    exp_time_a(0, 0, 10, "up_in_run");

    pulse_a(1'b1, 1'b0, 1);
    exp_a(3, 1, "to_set_hr.mode");
    pulse_a(1'b0, 1'b1, 25);
    exp_a(2, 1, "hr_wrap25.hour");
    exp_a(4, 0, "set_hr.tick");

    pulse_a(1'b1, 1'b1, 1);
    exp_a(3, 2, "prio.mode");
    exp_a(2, 1, "prio.hour");
    pulse_a(1'b0, 1'b1, 61);
    exp_time_a(1, 1, 10, "min_wrap61");

    pulse_a(1'b1, 1'b0, 1);
    exp_a(3, 0, "resume.mode");
    exp_a(0, 0, "resume.sec");
    step(4);
    exp_a(4, 0, "resume4.tick");
    step(1);
    exp_a(4, 1, "resume5.tick");
    step(1);
    exp_a(0, 1, "resume6.sec");

    // Preload 23:59, then count sec up to 59 and cross midnight
    pulse_a(1'b1, 1'b0, 1);
    pulse_a(1'b0, 1'b1, 22);
    exp_a(2, 23, "preload.hour");
    pulse_a(1'b1, 1'b0, 1);
    pulse_a(1'b0, 1'b1, 58);
    exp_a(1, 59, "preload.min");
    pulse_a(1'b1, 1'b0, 1);
    step(354);
    exp_time_a(23, 59, 59, "pre_roll");
    step(5);
    exp_a(4, 1, "pre_roll.tick");
    step(1);
    exp_time_a(0, 0, 0, "rollover");

    // Tick collides with mode_pls at xx:59:59
    pulse_a(1'b1, 1'b0, 1);
    pulse_a(1'b1, 1'b0, 1);
    pulse_a(1'b0, 1'b1, 59);
    pulse_a(1'b1, 1'b0, 1);
    step(359);
    exp_time_a(0, 59, 59, "pre_coll");
    exp_a(4, 1, "pre_coll.tick");
    pulse_a(1'b1, 1'b0, 1);
    exp_time_a(1, 0, 0, "collision");
    exp_a(3, 1, "collision.mode");
    exp_a(6, 0, "clear");
    step(20);
    exp_a(5, 0, "set_hr.no_ticks");
    exp_a(3, 1, "set_hr.mode_hold");

    // DIV=2 unit: tick every other cycle, 120 cycles = one minute
    rst_b = 1'b0;
    step(1);
    q.push_back('{14, 1, "b_edge1.tick"});
    q.push_back('{10, 0, "b_edge1.sec"});
    step(119);
    q.push_back('{10, 0, "b_120.sec"});
    q.push_back('{11, 1, "b_120.min"});
    q.push_back('{12, 0, "b_120.hour"});
    q.push_back('{13, 0, "b_120.mode"});

    step(1);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
